// File: rtl/wvb_rd_arb.sv
// Round-robin scanner over waveform-buffer channels that hands each event to the
// read controller and presents every filled DPRAM to the host, including continuations.
module wvb_rd_arb #(
    parameter int P_N_CHAN    = 24,
    parameter int P_CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   dpram_mode_cfg,
    input  logic [P_N_CHAN-1:0]    wvb_not_empty,
    output logic                   req,
    output logic [7:0]             idx,
    output logic                   dpram_mode,
    input  logic                   ack,
    input  logic                   rd_ctrl_more,
    input  logic [15:0]            rd_len,
    output logic                   dpram_rdy,
    output logic [15:0]            dpram_len,
    output logic                   dpram_more,
    input  logic                   dpram_done,
    output logic [P_CNT_WIDTH-1:0] evt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_REQ,
        S_ACK_LOW,
        S_HOST
    } state_t;

    localparam logic [7:0] LAST_CHAN = 8'(P_N_CHAN - 1);

    state_t              state;
    logic [7:0]          ptr;
    logic [P_N_CHAN-1:0] ne_shift;
    logic                ptr_ne;

    // Shift rather than index so the 8-bit pointer works for any channel count.
    assign ne_shift = wvb_not_empty >> ptr;
    assign ptr_ne   = ne_shift[0];

    function automatic logic [7:0] next_chan(input logic [7:0] c);
        return (c == LAST_CHAN) ? 8'd0 : c + 8'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= 8'd0;
            req        <= 1'b0;
            idx        <= 8'd0;
            dpram_mode <= 1'b0;
            dpram_rdy  <= 1'b0;
            dpram_len  <= 16'd0;
            dpram_more <= 1'b0;
            evt_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en)
                        state <= S_SCAN;
                end
                S_SCAN: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (ptr_ne) begin
                        idx        <= ptr;
                        dpram_mode <= dpram_mode_cfg;
                        req        <= 1'b1;
                        state      <= S_REQ;
                    end else begin
                        ptr <= next_chan(ptr);
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        dpram_len  <= rd_len;
                        dpram_more <= rd_ctrl_more;
                        req        <= 1'b0;
                        state      <= S_ACK_LOW;
                    end
                end
                // The read controller must observe req low before the host sees the DPRAM.
                S_ACK_LOW: begin
                    if (!ack) begin
                        dpram_rdy <= 1'b1;
                        state     <= S_HOST;
                    end
                end
                S_HOST: begin
                    if (dpram_done) begin
                        dpram_rdy <= 1'b0;
                        dpram_len <= 16'd0;
                        if (dpram_more) begin
                            req   <= 1'b1;
                            state <= S_REQ;
                        end else begin
                            evt_cnt <= evt_cnt + P_CNT_WIDTH'(1);
                            ptr     <= next_chan(idx);
                            state   <= en ? S_SCAN : S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/wvb_rd_arb.md
Name: wvb_rd_arb

Overview:
- Round-robin arbiter and DPRAM handoff sequencer for the mDOM waveform-buffer readout path.
- Sits directly upstream of the format-0 read controller. It scans per-channel waveform-buffer not-empty flags and issues req/idx/dpram_mode to the read controller. It collects the ack/rd_ctrl_more/dpram_len result and presents each filled DPRAM to the direct-readout host.
- Handles multi-DPRAM continuation (mode 1) by re-requesting the same channel after the host drains each DPRAM.

Parameters:
P_N_CHAN, 24, number of waveform-buffer channels scanned (1..256)
P_CNT_WIDTH, 32, width of completed-event counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
en  input  1  readout enable; sampled only at scan points
dpram_mode_cfg  input  1  DPRAM mode to apply (0 truncate, 1 extend); latched per event
wvb_not_empty  input  P_N_CHAN  per-channel buffer holds at least one complete waveform
req  output  1  request to read controller
idx  output  8  channel number to read controller
dpram_mode  output  1  latched mode to read controller
ack  input  1  read controller done with current DPRAM
rd_ctrl_more  input  1  valid with ack: event continues into next DPRAM
rd_len  input  16  valid with ack: DPRAM fill in 16-bit words
dpram_rdy  output  1  DPRAM contents valid for host
dpram_len  output  16  latched rd_len, valid while dpram_rdy
dpram_more  output  1  latched rd_ctrl_more, valid while dpram_rdy
dpram_done  input  1  single-cycle pulse from host: DPRAM drained
evt_cnt  output  P_CNT_WIDTH  number of events fully read out (wraps)

Behaviour:
- Reset (async, immediate): req=0, idx=0, dpram_mode=0, dpram_rdy=0, dpram_len=0, dpram_more=0, evt_cnt=0, scan pointer=0, fsm=S_IDLE. Reset asserted mid-event abandons the event. The read controller has its own reset.
- S_IDLE: if en, go to S_SCAN; otherwise stay.
- S_SCAN: checks one channel per cycle, at ptr.
  - If wvb_not_empty[ptr]: idx<=ptr, dpram_mode<=dpram_mode_cfg, req<=1, go to S_REQ.
  - Otherwise ptr<=ptr+1, wrapping P_N_CHAN-1 -> 0.
  - If en is low in S_SCAN, go to S_IDLE without asserting req.
  - Worst-case latency from not-empty to req is P_N_CHAN cycles.
- S_REQ: hold req=1 and idx stable until ack=1. On the ack cycle:
  - dpram_len<=rd_len, dpram_more<=rd_ctrl_more, req<=0; go to S_ACK_LOW.
- S_ACK_LOW: wait for ack=0, so the read controller has seen req low. Then dpram_rdy<=1; go to S_HOST.
- S_HOST: hold dpram_rdy=1 with dpram_len/dpram_more stable until the dpram_done pulse. On dpram_done: dpram_rdy<=0, dpram_len<=0.
  - If dpram_more=1: req<=1 with the same idx; go to S_REQ. This is a continuation and ignores en.
  - Otherwise: evt_cnt<=evt_cnt+1, ptr<=idx+1 (wrapping), go to S_SCAN if en, else S_IDLE.
- dpram_done outside S_HOST is ignored. dpram_done in the same cycle dpram_rdy rises is ignored.
- ack seen outside S_REQ is ignored.
- en deassertion never truncates an event: all continuation DPRAMs complete first.
- dpram_mode is held constant from first req to final dpram_done of an event. dpram_mode_cfg changes mid-event take effect on the next event.
- Fairness: after serving channel k, scanning resumes at k+1, so a continuously non-empty channel cannot starve others.
- The not-empty flag is re-sampled only at scan. Mid-event flag changes are ignored.
- evt_cnt wraps modulo 2^P_CNT_WIDTH without saturating.
- Minimum req-to-req gap between events is 3 cycles (S_ACK_LOW, S_HOST done, S_SCAN), plus host drain time.

Test Plan:
- wvb_not_empty=24'h000010, en=1, read-controller model acks with rd_len=40, more=0 -> req with idx=4; dpram_rdy with dpram_len=40; after dpram_done, evt_cnt=1, req stays 0.
- Channels 2 and 20 both non-empty and held non-empty -> service order 2, 20, 2, 20…; idx never repeats consecutively.
- dpram_mode_cfg=1, model returns more=1 twice then more=0 (lens 2046, 2046, 310) -> three dpram_rdy windows, all idx=7 with dpram_mode=1; evt_cnt increments by 1 only after the third.
- en dropped while in S_HOST with dpram_more=1 -> continuation req still issued; after the final DPRAM, fsm goes to S_IDLE with no further req.
- ack held high two extra cycles after req falls -> dpram_rdy asserts only the cycle after ack=0. Spurious dpram_done while in S_REQ -> no effect.
- rst pulsed asynchronously while dpram_rdy=1 -> req, dpram_rdy, dpram_len and evt_cnt are all 0 before the next clock edge; the scan restarts at channel 0.
